bcd_conv_arbiter: RTL
=====================

Name: bcd_conv_arbiter

Overview:
Shares one bin2bcd converter instance between NUM_REQ requesters, such as on-screen numeric overlays in the VGA pipeline.
- Arbitrates pending requests round-robin.
- Drives the converter's start/binary inputs and waits for its done pulse.
- Returns the BCD result with a one-cycle ack to the granted requester.
- A watchdog aborts a conversion if done never arrives.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
BINARY_DATA_WIDTH, 16, width of binary operands
BCD_DIGITS, 5, number of BCD digits in the result
TIMEOUT_CYCLES, 64, max cycles in WAIT before abort (>=2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req  in  NUM_REQ  per-requester request, held until ack
req_binary  in  NUM_REQ x BINARY_DATA_WIDTH  per-requester operand, stable while req high
ack  out  NUM_REQ  one-hot, one-cycle pulse; bcd_out/err valid in the same cycle
bcd_out  out  BCD_DIGITS x 4  result, packed, digit BCD_DIGITS-1 most significant
err  out  1  qualifies ack: 1 = timed out, bcd_out all zero
busy  out  1  high in every state except IDLE
conv_start  out  1  to converter start
conv_binary  out  BINARY_DATA_WIDTH  to converter binary
conv_done  in  1  from converter done, one-cycle pulse
conv_bcd  in  BCD_DIGITS x 4  from converter bcd, valid when conv_done high

Behaviour:
- Converter contract: start is sampled only while the converter is idle. done pulses exactly once per start, with bcd valid in that cycle. The converter shares clk and reset with this block.
- Reset values: ack=0, bcd_out=0, err=0, busy=0, conv_start=0, conv_binary=0, state=IDLE, last_grant=NUM_REQ-1 (requester 0 wins first), timer=0.
- FSM states: IDLE, START, WAIT, RESP.
- IDLE:
  - If any req bit is set, grant the first set bit searching from last_grant+1 upward, wrapping modulo NUM_REQ.
  - Latch the grant index and req_binary[index] into conv_binary.
  - Go to START. If no req, stay in IDLE.
- START:
  - conv_start=1 for exactly this cycle; timer cleared.
  - Go to WAIT.
- WAIT:
  - conv_start=0; timer increments each cycle.
  - On conv_done: latch conv_bcd into bcd_out, err=0, go to RESP.
  - Otherwise, when timer reaches TIMEOUT_CYCLES-1: bcd_out=0, err=1, go to RESP.
  - If conv_done and timeout occur in the same cycle, conv_done wins (err=0).
- RESP:
  - ack[index]=1 for one cycle; bcd_out and err are driven.
  - last_grant=index.
  - Go to IDLE.
- bcd_out and err hold their values after RESP until the next RESP. ack is 0 outside RESP.
- Latency: req seen in IDLE at cycle 0 -> conv_start at cycle 1 -> conv_done at cycle 1+L -> ack at cycle 2+L.
- Minimum spacing between two grants: 4 cycles (zero-latency converter case).
- Requester rule: deassert req in the cycle after ack. If req is still high when the FSM is back in IDLE, it is treated as a new request and arbitrated normally. Round-robin order guarantees the other requesters are served first.
- req changes while that requester is not granted are allowed. req_binary changes after the IDLE latch cycle have no effect on the conversion in progress.
- A conv_done pulse outside WAIT (stale pulse after a timeout) is ignored.
- Reset in any state: the FSM returns to IDLE within the same edge. No ack is issued for the aborted request. The requester keeps req high and is re-arbitrated normally.
- Starvation bound: a held request is granted within NUM_REQ grants.

Test Plan:
- Single request: req[0]=1, binary 0x00FF -> conv_start pulses once, ack[0] pulses once, bcd_out = 0,0,2,5,5, err=0.
- Simultaneous requests after reset: req=4'b1111 with operands 0xFFFF, 0x0000, 0xBEEF, 0x00FF (each requester drops req after its ack) -> ack order 0,1,2,3; results 6,5,5,3,5 / 0,0,0,0,0 / 4,8,8,7,9 / 0,0,2,5,5.
- Fairness: req[2] held high continuously while req[1] is raised during requester 2's conversion -> next grant goes to 1, then to 2 again.
- Timeout: stub converter never asserts conv_done, TIMEOUT_CYCLES=64 -> ack pulses 64 cycles after entering WAIT (66 after the IDLE sample), err=1, bcd_out=0. A later stale conv_done is ignored and busy stays 0.
- Reset mid-WAIT: assert reset for 1 cycle during requester 1's conversion -> no ack, busy=0 and all outputs at reset values the next cycle. With req[1] still high, it is re-granted first among pending requesters ≥1 after requester 0, and completes correctly.
- Zero-latency stub (conv_done in the cycle after start) -> ack exactly 3 cycles after the IDLE grant; back-to-back grants spaced exactly 4 cycles.

Source files
------------

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter that time-shares one bin2bcd converter between NUM_REQ requesters.
// Each grant runs START -> WAIT -> RESP; a watchdog ends WAIT with err=1 if done never arrives.
module bcd_conv_arbiter #(
    parameter int NUM_REQ           = 4,
    parameter int BINARY_DATA_WIDTH = 16,
    parameter int BCD_DIGITS        = 5,
    parameter int TIMEOUT_CYCLES    = 64
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_REQ-1:0]                     req,
    input  logic [NUM_REQ*BINARY_DATA_WIDTH-1:0]   req_binary,
    output logic [NUM_REQ-1:0]                     ack,
    output logic [BCD_DIGITS*4-1:0]                bcd_out,
    output logic                                   err,
    output logic                                   busy,
    output logic                                   conv_start,
    output logic [BINARY_DATA_WIDTH-1:0]           conv_binary,
    input  logic                                   conv_done,
    input  logic [BCD_DIGITS*4-1:0]                conv_bcd
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]                   r_state;
    logic [IDX_W-1:0]             r_grant;
    logic [IDX_W-1:0]             r_last;
    logic [TMR_W-1:0]             r_timer;
    logic [NUM_REQ-1:0]           r_ack;
    logic [BCD_DIGITS*4-1:0]      r_bcd;
    logic                         r_err;
    logic                         r_conv_start;
    logic [BINARY_DATA_WIDTH-1:0] r_conv_binary;

    logic [BINARY_DATA_WIDTH-1:0] w_ops [NUM_REQ];
    logic                         w_any;
    logic [IDX_W-1:0]             w_next;
    logic [IDX_W:0]               w_sum;
    logic [NUM_REQ-1:0]           w_onehot;
    logic                         w_timeout;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_ops
        assign w_ops[g] = req_binary[g*BINARY_DATA_WIDTH +: BINARY_DATA_WIDTH];
    end

    // Walk from farthest to nearest so the first set bit after r_last overwrites the rest.
    always_comb begin
        w_any  = 1'b0;
        w_next = r_last;
        w_sum  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_sum = {1'b0, r_last} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(NUM_REQ))
                w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
            if (req[w_sum[IDX_W-1:0]]) begin
                w_any  = 1'b1;
                w_next = w_sum[IDX_W-1:0];
            end
        end
    end

    assign w_onehot  = NUM_REQ'(1) << r_grant;
    assign w_timeout = (r_timer == TMR_W'(TIMEOUT_CYCLES-1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_grant       <= '0;
            r_last        <= IDX_W'(NUM_REQ-1);
            r_timer       <= '0;
            r_ack         <= '0;
            r_bcd         <= '0;
            r_err         <= 1'b0;
            r_conv_start  <= 1'b0;
            r_conv_binary <= '0;
        end else begin
            r_ack        <= '0;
            r_conv_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant       <= w_next;
                        r_conv_binary <= w_ops[w_next];
                        r_conv_start  <= 1'b1;
                        r_state       <= S_START;
                    end
                end
                S_START: begin
                    r_timer <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_timer <= r_timer + TMR_W'(1);
                    // done takes priority over a watchdog expiring in the same cycle
                    if (conv_done) begin
                        r_bcd   <= conv_bcd;
                        r_err   <= 1'b0;
                        r_ack   <= w_onehot;
                        r_state <= S_RESP;
                    end else if (w_timeout) begin
                        r_bcd   <= '0;
                        r_err   <= 1'b1;
                        r_ack   <= w_onehot;
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_last  <= r_grant;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ack         = r_ack;
    assign bcd_out     = r_bcd;
    assign err         = r_err;
    assign busy        = (r_state != S_IDLE);
    assign conv_start  = r_conv_start;
    assign conv_binary = r_conv_binary;
endmodule
